// File: rtl/ll_pkg.sv
// Shared helpers for the linked-list multi-FIFO family: index width and
// round-robin pointer increment with explicit wrap for non power-of-two counts.
package ll_pkg;

   // Depth of the drain output buffer.
   localparam int unsigned BUF_DEPTH = 2;

   // Width needed to index n FIFOs (at least one bit).
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next round-robin index after idx, wrapping from n-1 back to 0.
   function automatic int unsigned rr_incr(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ll_rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning from rr_ptr, registered
// pointer that moves past the granted index whenever a grant is consumed.
module ll_rr_arbiter
   import ll_pkg::*;
#(
   parameter int unsigned NUM_FIFOS = 2,
   parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_FIFOS-1:0] elig,
   input  logic                 advance,
   output logic [SEL_WIDTH-1:0] grant,
   output logic                 any_elig
);

   logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   // First eligible index at or after rr_ptr, modulo NUM_FIFOS.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
         if (!found && elig[idx]) begin
            found = 1'b1;
            grant = SEL_WIDTH'(idx);
         end
      end
      any_elig = |elig;
   end

   // Pointer moves one past the winner on a consumed grant, holds otherwise.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (advance) rr_ptr_d = SEL_WIDTH'(rr_incr(32'(grant), NUM_FIFOS));
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/ll_fifo_drain.sv
// Drains the multi-FIFO in round-robin order into a 2-entry output buffer
// presented as a valid/ready stream tagged with the source FIFO index.
// The buffer head is a register, so out_data/out_sel come straight from flops
// and out_ready never reaches pop combinationally (pop only looks at count).
module ll_fifo_drain
   import ll_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_FIFOS = 2,
   parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_FIFOS-1:0] en,
   input  logic [NUM_FIFOS-1:0] empty,
   output logic                 pop,
   output logic [SEL_WIDTH-1:0] pop_sel,
   input  logic [WIDTH-1:0]     pop_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel,
   output logic                 idle
);

   localparam logic [1:0] CntFull = 2'(BUF_DEPTH);

   logic [NUM_FIFOS-1:0] elig;
   logic                 any_elig;
   logic [SEL_WIDTH-1:0] grant;
   logic                 rd;

   logic [1:0]           count_q, count_d;
   logic [WIDTH-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [SEL_WIDTH-1:0] head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;

   assign elig = en & ~empty;

   ll_rr_arbiter #(
      .NUM_FIFOS (NUM_FIFOS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .elig     (elig),
      .advance  (pop),
      .grant    (grant),
      .any_elig (any_elig)
   );

   // Pop request and stream outputs; pop is held low while in reset.
   always_comb begin
      pop       = rst_n & any_elig & (count_q != CntFull);
      pop_sel   = grant;
      out_valid = (count_q != 2'd0);
      out_data  = head_data_q;
      out_sel   = head_sel_q;
      idle      = (count_q == 2'd0) & ~any_elig;
      rd        = out_valid & out_ready;
   end

   // Buffer next state: head is the oldest word, tail the second one.
   always_comb begin
      count_d     = count_q;
      head_data_d = head_data_q;
      head_sel_d  = head_sel_q;
      tail_data_d = tail_data_q;
      tail_sel_d  = tail_sel_q;
      case (count_q)
         2'd0: begin
            if (pop) begin
               head_data_d = pop_data;
               head_sel_d  = pop_sel;
               count_d     = 2'd1;
            end
         end
         2'd1: begin
            if (pop && rd) begin
               // Head leaves and the new word takes its place.
               head_data_d = pop_data;
               head_sel_d  = pop_sel;
            end else if (pop) begin
               tail_data_d = pop_data;
               tail_sel_d  = pop_sel;
               count_d     = 2'd2;
            end else if (rd) begin
               count_d = 2'd0;
            end
         end
         2'd2: begin
            // No pop is issued when full, so only a read can happen.
            if (rd) begin
               head_data_d = tail_data_q;
               head_sel_d  = tail_sel_q;
               count_d     = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   // Buffer registers; reset discards any buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_data_q <= '0;
         head_sel_q  <= '0;
         tail_data_q <= '0;
         tail_sel_q  <= '0;
      end else begin
         count_q     <= count_d;
         head_data_q <= head_data_d;
         head_sel_q  <= head_sel_d;
         tail_data_q <= tail_data_d;
         tail_sel_q  <= tail_sel_d;
      end
   end

endmodule

// File: tb/tb_ll_fifo_drain.sv
// Scoreboard bench for ll_fifo_drain with three FIFOs (non power of two).
module tb_ll_fifo_drain;

   localparam int N  = 3;
   localparam int W  = 8;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  en;
   logic [N-1:0]  empty;
   logic          pop;
   logic [SW-1:0] pop_sel;
   logic [W-1:0]  pop_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_sel;
   logic          idle;

   always #5 clk = ~clk;

   ll_fifo_drain #(
      .WIDTH     (W),
      .NUM_FIFOS (N),
      .SEL_WIDTH (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .empty     (empty),
      .pop       (pop),
      .pop_sel   (pop_sel),
      .pop_data  (pop_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .idle      (idle)
   );

   int checks = 0;
   int errors = 0;

   // Multi-FIFO stand-in: fixed random contents, write level and read index.
   logic [W-1:0] fifo_mem [N][256];
   int           rd_idx [N];
   int           wr_lvl [N];
   int           s_add [N];
   logic [N-1:0] s_en;
   logic         s_rdy;

   always_comb begin
      for (int i = 0; i < N; i++) empty[i] = (rd_idx[i] >= wr_lvl[i]);
   end

   always_comb begin
      pop_data = '0;
      if (32'(pop_sel) < N) pop_data = fifo_mem[pop_sel][rd_idx[pop_sel] % 256];
   end

   always @(posedge clk) begin
      if (rst_n && pop && 32'(pop_sel) < N) rd_idx[pop_sel] <= rd_idx[pop_sel] + 1;
   end

   // Reference model state.
   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] sel;
   } exp_t;

   exp_t sbq[$];
   int   m_count;
   int   m_rr;
   int   pop_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: predict pop/pop_sel/idle from en, empty and the model's own
   // occupancy and pointer; queue the word the output side must later see.
   task automatic model_step();
      logic [N-1:0] elig;
      logic         exp_pop;
      logic         rd;
      int           g;
      if (!rst_n) begin
         chk("pop_in_reset", 32'(pop), 0);
         return;
      end
      elig    = en & ~empty;
      rd      = (m_count != 0) && out_ready;
      exp_pop = (elig != 0) && (m_count < 2);
      chk("idle", 32'(idle), 32'((m_count == 0) && (elig == 0)));
      chk("pop", 32'(pop), 32'(exp_pop));
      if (exp_pop) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
         chk("pop_sel", 32'(pop_sel), g);
         sbq.push_back({fifo_mem[g][rd_idx[g] % 256], SW'(g)});
         m_rr = (g + 1) % N;
      end
      m_count = m_count + (exp_pop ? 1 : 0) - (rd ? 1 : 0);
      if (pop) pop_log.push_back(int'(pop_sel));
   endtask

   // One cycle: apply staged inputs at the falling edge, then run the model.
   task automatic step();
      @(negedge clk);
      en        = s_en;
      out_ready = s_rdy;
      for (int i = 0; i < N; i++) begin
         wr_lvl[i] = (wr_lvl[i] + s_add[i] > 256) ? 256 : wr_lvl[i] + s_add[i];
         s_add[i]  = 0;
      end
      #2;
      model_step();
   endtask

   // Monitor: checks the output stream against the scoreboard queue.
   logic         hold;
   logic [W-1:0] held_data;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
         if (hold && out_valid) chk("out_data_held", 32'(out_data), 32'(held_data));
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0d sel %0d expected none", out_data, out_sel);
            end else begin
               e = sbq.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_sel", 32'(out_sel), 32'(e.sel));
            end
         end
         hold      = out_valid && !out_ready;
         held_data = out_data;
      end
   end

   task automatic chk_seq(input string name, input int exp0, input int exp1,
                          input int exp2, input int exp3, input int n);
      int exp_arr[4];
      exp_arr = '{exp0, exp1, exp2, exp3};
      if (pop_log.size() < n) begin
         chk({name, "_len"}, pop_log.size(), n);
      end else begin
         for (int i = 0; i < n; i++) chk(name, pop_log[i], exp_arr[i]);
      end
   endtask

   initial begin
      int guard;
      int npop;
      rst_n     = 1'b0;
      en        = '0;
      out_ready = 1'b0;
      s_en      = '0;
      s_rdy     = 1'b0;
      hold      = 1'b0;
      held_data = '0;
      m_count   = 0;
      m_rr      = 0;
      for (int i = 0; i < N; i++) begin
         rd_idx[i] = 0;
         wr_lvl[i] = 0;
         s_add[i]  = 0;
         for (int j = 0; j < 256; j++) fifo_mem[i][j] = W'($urandom);
      end

      // Reset values.
      #1;
      chk("rst_pop", 32'(pop), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_sel", 32'(out_sel), 0);
      repeat (2) step();
      #1 rst_n = 1'b1;

      // Fairness: all enabled and non-empty, ready high.
      for (int i = 0; i < N; i++) s_add[i] = 20;
      s_en  = 3'b111;
      s_rdy = 1'b1;
      pop_log.delete();
      repeat (8) step();
      chk_seq("fair_a", 0, 1, 2, 0, 4);
      if (pop_log.size() >= 6) begin
         chk("fair_b", pop_log[4], 1);
         chk("fair_c", pop_log[5], 2);
      end

      // Backpressure: exactly two pops, then drain in order.
      s_en = '0;
      repeat (3) step();
      s_en  = 3'b111;
      s_rdy = 1'b0;
      npop  = 0;
      repeat (5) begin
         step();
         if (pop) npop++;
      end
      chk("bp_pops", npop, 2);
      s_rdy = 1'b1;
      repeat (6) step();

      // Reset mid-stream with a full buffer.
      s_rdy = 1'b0;
      repeat (3) step();
      chk("pre_rst_valid", 32'(out_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_pop", 32'(pop), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      chk("mid_rst_sel", 32'(out_sel), 0);
      sbq.delete();
      m_count = 0;
      m_rr    = 0;
      s_en    = '0;
      s_rdy   = 1'b1;
      repeat (2) step();
      #1 rst_n = 1'b1;
      s_en = 3'b111;
      pop_log.delete();
      step();
      chk_seq("first_after_rst", 0, 0, 0, 0, 1);
      repeat (2) step();

      // Skip and wrap: empty FIFO 1, point rr at 1, expect 2,0,2,0.
      s_en  = 3'b010;
      guard = 0;
      while (!empty[1] && guard < 200) begin
         step();
         guard++;
      end
      chk("drain_fifo1_timeout", 32'(empty[1]), 1);
      s_en = '0;
      repeat (3) step();
      s_add[0] = 10;
      s_add[2] = 10;
      s_en     = 3'b001;
      step();
      s_en = '0;
      repeat (2) step();
      pop_log.delete();
      s_en = 3'b111;
      repeat (5) step();
      chk_seq("skip_wrap", 2, 0, 2, 0, 4);

      // Enable mask: only FIFO 0 drains; idle once it and the buffer are empty.
      s_en  = 3'b001;
      guard = 0;
      while (!empty[0] && guard < 300) begin
         step();
         guard++;
      end
      chk("drain_fifo0_timeout", 32'(empty[0]), 1);
      repeat (3) step();
      chk("mask_fifo2_kept", 32'(empty[2]), 0);
      chk("mask_idle", 32'(idle), 1);

      // Randomized traffic.
      repeat (400) begin
         s_en  = N'($urandom);
         s_rdy = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++) begin
            if ($urandom % 3 == 0) s_add[i] = $urandom_range(0, 3);
         end
         step();
      end

      // Final drain.
      s_en  = '0;
      s_rdy = 1'b1;
      repeat (5) step();
      chk("sb_empty", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ll_fifo_drain.md
# ll_fifo_drain

Read-side companion to the shared-memory multi-FIFO. Watches the per-FIFO `empty` flags, issues one-hot-free `pop`/`pop_sel` requests in round-robin order among enabled non-empty FIFOs, captures the popped word and emits it on a valid/ready output stream tagged with its source FIFO index. A 2-entry output buffer decouples the downstream `out_ready` from the pop path, so there is no combinational path from `out_ready` to `pop`.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the multi-FIFO.
- `NUM_FIFOS`, 2, number of FIFOs drained; any value ≥ 2, not required to be a power of two.
- `SEL_WIDTH`, `$clog2(NUM_FIFOS)`, FIFO index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  NUM_FIFOS  bit i = 1 allows FIFO i to be drained.
- `empty`  in  NUM_FIFOS  per-FIFO empty flags from the multi-FIFO.
- `pop`  out  1  pop request to the multi-FIFO.
- `pop_sel`  out  SEL_WIDTH  FIFO index being popped; valid only when `pop`=1.
- `pop_data`  in  WIDTH  multi-FIFO read data; valid in the same cycle as `pop`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  output word.
- `out_sel`  out  SEL_WIDTH  source FIFO of `out_data`.
- `idle`  out  1  buffer empty and no eligible FIFO.

## Operation
- Eligibility: `elig[i] = en[i] & ~empty[i]`.
- Round-robin pointer `rr_ptr` (SEL_WIDTH bits, range 0..NUM_FIFOS-1). Grant = first eligible index scanning `rr_ptr`, `rr_ptr+1`, … modulo NUM_FIFOS.
- `pop = (|elig) & (count < 2)`; `pop_sel = grant`. `pop` is never asserted for an empty or disabled FIFO.
- On a pop, `rr_ptr <= grant+1`, wrapping from NUM_FIFOS-1 to 0. This explicit wrap is required when NUM_FIFOS is not a power of two. `rr_ptr` holds otherwise.
- Output buffer: 2 entries {data, sel}, FIFO order, `count` ∈ {0,1,2}.
  - Write on `pop` with {`pop_data`, `pop_sel`}.
  - Read on `out_valid & out_ready`.
- Simultaneous write and read: count unchanged, order preserved. Write at count 0 with read is impossible (`out_valid`=0).
- `out_valid = (count != 0)`. `out_data`/`out_sel` = oldest entry, driven from registers.
- `idle = (count == 0) & ~(|elig)`.
- Changing `en` takes effect in the same cycle's grant. Already-buffered words are still emitted.

## Timing
- Reset (async assert, sync deassert handled by system): `count`=0, `rr_ptr`=0, `out_valid`=0, `out_data`=0, `out_sel`=0, `pop`=0 while `rst_n`=0.
- Pop-to-output latency: 1 cycle (word popped in cycle N is visible on `out_valid` in N+1 if the buffer was empty).
- Throughput: 1 word/cycle sustained with `out_ready` held high (count stays at 1).
- Backpressure: `out_ready`=0 fills the buffer to 2, then `pop` deasserts. `out_data` is stable while `out_valid & ~out_ready`.
- Reset mid-operation discards buffered words. The multi-FIFO must share the same reset so no popped word is orphaned.

## Structure
- Shared package/header `ll_pkg`: the FIFO-index width computation and the modulo-increment helper for round-robin pointers, shared with the multi-FIFO and linked-list blocks.
- One sub-module: `ll_rr_arbiter` (combinational grant from `elig` and `rr_ptr`, plus the registered `rr_ptr` update). Buffer and handshake logic stay in `ll_fifo_drain`.

## Test plan
- Reset: hold `rst_n`=0 mid-stream with count=2 → all outputs 0 immediately, count=0. After release, first pop is from FIFO 0 if eligible.
- Fairness: NUM_FIFOS=3, all enabled, all non-empty, `out_ready`=1 → `pop_sel` sequence 0,1,2,0,1,2; `out_sel` identical, delayed 1 cycle.
- Skip and wrap: `empty`=3'b010, `rr_ptr`=1 → grants 2, 0, 2, 0. FIFO 1 is never popped.
- Backpressure: `out_ready`=0 for 5 cycles with data available → exactly 2 pops, then `pop`=0. `out_data` is held. On `out_ready`=1, the words drain in pop order at 1 word/cycle.
- Enable mask: `en`=2'b01 with both FIFOs non-empty → only FIFO 0 is popped. When FIFO 0 runs empty, `idle`=1 once the buffer drains.
- Simultaneous push/pop at count=1 for 10 cycles → count remains 1, 10 words out in order, no word lost or duplicated.
